// File: rtl/eth_fcs_tx.sv
// -----------------------------------------------------------------------------
// eth_fcs_tx
//
// Purpose:
//   Ethernet TX Frame Check Sequence generator. Frame bytes arriving on a
//   valid/ready stream are forwarded unchanged through a single registered
//   output slot. A reflected CRC-32 is accumulated over every forwarded byte.
//   The four FCS bytes are appended, least significant byte first, after the
//   last frame byte. Frames run back to back at one byte per cycle.
//
// Optional feature (compile-time macro):
//   FCS_PAD_EN - When defined, a frame shorter than MIN_LEN bytes is extended
//                with 0x00 bytes up to exactly MIN_LEN before the FCS. The pad
//                bytes are included in the CRC. When undefined, the PAD state
//                and the length compare are not built, and MIN_LEN has no
//                effect.
//
// Parameters:
//   INIT     CRC register value at reset and at the start of every frame
//   MIN_LEN  minimum byte count before the FCS (padding build only)
//
// Ports:
//   clk        in   system clock; all logic runs on the rising edge
//   rst        in   synchronous active-high reset
//   s_data     in   [7:0] input frame byte
//   s_valid    in   s_data valid
//   s_last     in   s_data is the final byte of the frame
//   s_ready    out  block accepts s_data this cycle (low during rst)
//   m_data     out  [7:0] output byte (data, pad or FCS)
//   m_valid    out  m_data valid
//   m_last     out  m_data is the final FCS byte
//   m_ready    in   downstream accepts m_data
//   busy       out  high from the first accepted byte until the final FCS
//                   byte is loaded
//   frame_cnt  out  [15:0] count of frames whose final FCS byte was accepted
//                   downstream; wraps at 2^16
// -----------------------------------------------------------------------------
module eth_fcs_tx #(
  parameter logic [31:0] INIT    = 32'hFFFF_FFFF,
  parameter int unsigned MIN_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
`ifdef FCS_PAD_EN
    ST_PAD  = 3'd2,
`endif
    ST_FCS0 = 3'd3,
    ST_FCS1 = 3'd4,
    ST_FCS2 = 3'd5,
    ST_FCS3 = 3'd6
  } state_t;

  state_t      state_q;
  logic [31:0] crc_q;
  logic [31:0] fcs_q;
  logic [15:0] count_q;
  logic [7:0]  m_data_q;
  logic        m_valid_q;
  logic        m_last_q;
  logic        busy_q;
  logic [15:0] frame_cnt_q;

  // The output slot can take a new byte when it is empty or being drained.
  logic load_ok;
  assign load_ok = !m_valid_q || m_ready;

  logic accept_state;
  assign accept_state = (state_q == ST_IDLE) || (state_q == ST_DATA);

  assign s_ready = !rst && accept_state && load_ok;

  logic s_fire;
  assign s_fire = s_valid && s_ready;

  // Byte entering the CRC this cycle: the input byte, or zero while padding.
  logic [7:0] crc_in;
  always_comb begin
    crc_in = s_data;
`ifdef FCS_PAD_EN
    if (state_q == ST_PAD) begin
      crc_in = 8'h00;
    end
`endif
  end

  // Byte-wide reflected CRC-32: XOR the byte in, then shift eight times.
  // Each stage handles one bit, LSB first.
  logic [31:0] crc_stage [0:8];
  assign crc_stage[0] = crc_q ^ {24'h000000, crc_in};

  for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
    assign crc_stage[gi+1] = crc_stage[gi][0]
                           ? ((crc_stage[gi] >> 1) ^ CRC_POLY_REFL)
                           : (crc_stage[gi] >> 1);
  end

  logic [31:0] crc_d;
  assign crc_d = crc_stage[8];

  // Byte count after the byte loaded this cycle. The count saturates rather
  // than wrapping, so an oversize frame can never look short.
  logic [15:0] count_inc;
  logic [15:0] count_d;
  assign count_inc = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);
  assign count_d   = (state_q == ST_IDLE) ? 16'd1 : count_inc;

`ifdef FCS_PAD_EN
  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
`else
  // Without padding, nothing reads MIN_LEN.
  logic unused_min_len;
  assign unused_min_len = ^32'(MIN_LEN);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT;
      fcs_q       <= 32'h0000_0000;
      count_q     <= 16'd0;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      // Drain the slot on a downstream handshake. A load below overrides
      // this in the same cycle.
      if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
        if (m_last_q) begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
      end

      case (state_q)
        ST_IDLE, ST_DATA: begin
          if (s_fire) begin
            m_data_q  <= s_data;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            crc_q     <= crc_d;
            count_q   <= count_d;
            busy_q    <= 1'b1;
            if (s_last) begin
`ifdef FCS_PAD_EN
              if (count_d < MIN_LEN_W) begin
                state_q <= ST_PAD;
              end else begin
                state_q <= ST_FCS0;
                fcs_q   <= ~crc_d;
              end
`else
              state_q <= ST_FCS0;
              fcs_q   <= ~crc_d;
`endif
            end else begin
              state_q <= ST_DATA;
            end
          end
        end

`ifdef FCS_PAD_EN
        ST_PAD: begin
          if (load_ok) begin
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            crc_q     <= crc_d;
            count_q   <= count_d;
            if (count_d == MIN_LEN_W) begin
              state_q <= ST_FCS0;
              fcs_q   <= ~crc_d;
            end
          end
        end
`endif

        // The FCS is frozen in fcs_q, so crc_q is free to reinitialise on
        // the last FCS byte and the next frame can start immediately.
        ST_FCS0: begin
          if (load_ok) begin
            m_data_q  <= fcs_q[7:0];
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            state_q   <= ST_FCS1;
          end
        end

        ST_FCS1: begin
          if (load_ok) begin
            m_data_q  <= fcs_q[15:8];
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            state_q   <= ST_FCS2;
          end
        end

        ST_FCS2: begin
          if (load_ok) begin
            m_data_q  <= fcs_q[23:16];
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b0;
            state_q   <= ST_FCS3;
          end
        end

        ST_FCS3: begin
          if (load_ok) begin
            m_data_q  <= fcs_q[31:24];
            m_valid_q <= 1'b1;
            m_last_q  <= 1'b1;
            crc_q     <= INIT;
            count_q   <= 16'd0;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_fcs_tx.sv
// -----------------------------------------------------------------------------
// tb_eth_fcs_tx
//
// Directed testbench for eth_fcs_tx. Expected bytes are hand-computed
// constants: "123456789" has CRC-32 0xCBF43926, so its FCS bytes are 26 39 F4
// CB. Padded frames are checked with the Ethernet residue 0xDEBB20E3, taken
// over every output byte. With FCS_PAD_EN defined, the padding scenarios run.
// Otherwise, the unpadded scenarios run.
// -----------------------------------------------------------------------------
module tb_eth_fcs_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic        busy;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  eth_fcs_tx dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] in_data[$];
  logic       in_last[$];
  logic [7:0] out_data[$];
  logic       out_last[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  int         first_acc;
  int         first_mv;
  int         run_cycles;
  logic [4:0] ready_pat = 5'b01001;  // m_ready per cycle: 1,0,0,1,0

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    exp_data.delete();
    exp_last.delete();
  endtask

  // Queue "123456789" as input, and its 13 output bytes as the expectation.
  task automatic push_ref_frame();
    for (int i = 0; i < 9; i++) begin
      in_data.push_back(8'(8'h31 + i));
      in_last.push_back(i == 8);
      exp_data.push_back(8'(8'h31 + i));
      exp_last.push_back(1'b0);
    end
    exp_data.push_back(8'h26); exp_last.push_back(1'b0);
    exp_data.push_back(8'h39); exp_last.push_back(1'b0);
    exp_data.push_back(8'hF4); exp_last.push_back(1'b0);
    exp_data.push_back(8'hCB); exp_last.push_back(1'b1);
  endtask

  task automatic check_data(input string tag);
    for (int i = 0; i < exp_data.size() && i < out_data.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(out_data[i]), 32'(exp_data[i]));
  endtask

  task automatic check_lasts(input string tag);
    for (int i = 0; i < exp_last.size() && i < out_last.size(); i++)
      check($sformatf("%s_last%0d", tag, i), 32'(out_last[i]), 32'(exp_last[i]));
  endtask

  function automatic logic [31:0] out_residue();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (out_data[i]) begin
      c = c ^ {24'h000000, out_data[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Drive the queued input bytes and collect output handshakes until all
  // input bytes are accepted and n_out bytes have been collected. The run
  // is bounded by a cycle budget. Stall behaviour is checked every cycle.
  task automatic run(input int n_out, input logic stall);
    int         idx;
    int         cyc;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    idx = 0; cyc = 0; prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    first_acc = -1; first_mv = -1;
    out_data.delete(); out_last.delete();
    while ((idx < in_data.size() || out_data.size() < n_out) && cyc < 3000) begin
      s_valid = (idx < in_data.size());
      s_data  = s_valid ? in_data[idx] : 8'h00;
      s_last  = s_valid ? in_last[idx] : 1'b0;
      m_ready = stall ? ready_pat[cyc % 5] : 1'b1;
      #1;
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(prev_data));
        check("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && !m_ready) check("sready_stall", 32'(s_ready), 32'd0);
      if (s_valid && s_ready) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (m_valid && m_ready) begin
        out_data.push_back(m_data);
        out_last.push_back(m_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      @(posedge clk); #1;
      cyc++;
    end
    check("run_timeout", 32'(cyc < 3000), 32'd1);
    run_cycles = cyc;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b1;
    in_data.delete(); in_last.delete();
    $display("[TB] run: %0d bytes out in %0d cycles, frame_cnt=%0d",
             out_data.size(), cyc, frame_cnt);
  endtask

  initial begin
    // Reset: s_ready must stay low while rst is high, even with s_valid set.
    s_valid = 1'b1; s_data = 8'h11;
    @(posedge clk); @(posedge clk); #1;
    check("rst_sready", 32'(s_ready), 32'd0);
    rst = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    #1;
    check("rst_mvalid", 32'(m_valid), 32'd0);
    check("rst_mlast", 32'(m_last), 32'd0);
    check("rst_mdata", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("idle_sready", 32'(s_ready), 32'd1);

`ifdef FCS_PAD_EN
    // One-byte frame padded to 60 bytes, then the 4 FCS bytes.
    clear_exp();
    in_data.push_back(8'hAA); in_last.push_back(1'b1);
    exp_data.push_back(8'hAA);
    for (int i = 1; i < 60; i++) exp_data.push_back(8'h00);
    for (int i = 0; i < 64; i++) exp_last.push_back(i == 63);
    run(64, 1'b0);
    check("pad1_len", 32'(out_data.size()), 32'd64);
    check_data("pad1");
    check_lasts("pad1");
    check("pad1_residue", out_residue(), 32'hDEBB_20E3);
    check("pad1_frame_cnt", 32'(frame_cnt), 32'd1);

    // 60-byte and 61-byte frames: no pad bytes, FCS follows directly.
    for (int len = 60; len <= 61; len++) begin
      clear_exp();
      for (int i = 0; i < len; i++) begin
        in_data.push_back(8'(i * 7 + 3));
        in_last.push_back(i == len - 1);
        exp_data.push_back(8'(i * 7 + 3));
      end
      for (int i = 0; i < len + 4; i++) exp_last.push_back(i == len + 3);
      run(len + 4, 1'b1);
      check($sformatf("nopad%0d_len", len), 32'(out_data.size()), 32'(len + 4));
      check_data($sformatf("nopad%0d", len));
      check_lasts($sformatf("nopad%0d", len));
      check($sformatf("nopad%0d_residue", len), out_residue(), 32'hDEBB_20E3);
    end
    check("pad_frame_cnt", 32'(frame_cnt), 32'd3);
`else
    // Test 1: "123456789", continuous flow.
    clear_exp();
    push_ref_frame();
    run(13, 1'b0);
    check("t1_len", 32'(out_data.size()), 32'd13);
    check_data("t1");
    check_lasts("t1");
    check("t1_latency", 32'(first_mv - first_acc), 32'd1);
    check("t1_cycles", 32'(run_cycles), 32'd14);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Test 2: same frame under the 1,0,0,1,0 m_ready pattern.
    clear_exp();
    push_ref_frame();
    run(13, 1'b1);
    check("t2_len", 32'(out_data.size()), 32'd13);
    check_data("t2");
    check_lasts("t2");
    check("t2_frame_cnt", 32'(frame_cnt), 32'd2);

    // Test 3: two back-to-back frames with no bubble between them.
    clear_exp();
    push_ref_frame();
    push_ref_frame();
    run(26, 1'b0);
    check("t3_len", 32'(out_data.size()), 32'd26);
    check_data("t3");
    check_lasts("t3");
    check("t3_cycles", 32'(run_cycles), 32'd27);
    check("t3_frame_cnt", 32'(frame_cnt), 32'd4);

    // Test 4: reset after 5 accepted bytes drops the partial frame.
    clear_exp();
    for (int i = 0; i < 5; i++) begin
      in_data.push_back(8'(8'h31 + i));
      in_last.push_back(1'b0);
    end
    run(4, 1'b0);
    check("t4_busy_mid", 32'(busy), 32'd1);
    for (int i = 0; i < out_last.size(); i++)
      check($sformatf("t4_abort_last%0d", i), 32'(out_last[i]), 32'd0);
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55; m_ready = 1'b0;
    #1;
    check("t4_rst_sready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;
    #1;
    check("t4_mvalid", 32'(m_valid), 32'd0);
    check("t4_mlast", 32'(m_last), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_frame_cnt_rst", 32'(frame_cnt), 32'd0);
    push_ref_frame();
    run(13, 1'b0);
    check("t4_len", 32'(out_data.size()), 32'd13);
    check_data("t4");
    check_lasts("t4");
    check("t4_frame_cnt", 32'(frame_cnt), 32'd1);

    // One-byte frame: no padding in this build, FCS directly after the byte.
    clear_exp();
    in_data.push_back(8'hAA); in_last.push_back(1'b1);
    exp_data.push_back(8'hAA);
    for (int i = 0; i < 5; i++) exp_last.push_back(i == 4);
    run(5, 1'b1);
    check("t5_len", 32'(out_data.size()), 32'd5);
    check_data("t5");
    check_lasts("t5");
    check("t5_residue", out_residue(), 32'hDEBB_20E3);
    check("t5_frame_cnt", 32'(frame_cnt), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
